// File: rtl/hp_pkg.sv
// Shared constants, FSM encoding and binary16 classification helpers for the HP arithmetic datapath.
package hp_pkg;

   localparam int QBITS = 13;
   localparam logic signed [6:0] EBIAS = 7'sd15;

   localparam logic [15:0] QNAN_VAL = 16'hFFFF;
   localparam logic [1:0]  EXC_NAN  = 2'b11;
   localparam logic [1:0]  EXC_POS  = 2'b01;
   localparam logic [1:0]  EXC_NEG  = 2'b10;
   localparam logic [1:0]  EXC_ZERO = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } hp_state_e;

   // Exponent field 0 covers both true zero and subnormals, which are flushed.
   function automatic logic is_zero(input logic [15:0] x);
      return (x[14:10] == 5'd0);
   endfunction

   function automatic logic is_inf(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
   endfunction

   function automatic logic is_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
   endfunction

   function automatic logic [1:0] sign_exc(input logic s);
      return s ? EXC_NEG : EXC_POS;
   endfunction

endpackage

// File: rtl/hp_mant_div_step.sv
// One restoring-division step: emit a quotient bit and produce the shifted partial remainder.
module hp_mant_div_step (
   input  logic [12:0] rem,
   input  logic [10:0] d,
   output logic        qbit,
   output logic [12:0] rem_next
);

   logic [12:0] diff_s;

   // Compare, conditionally subtract, then shift left for the next bit.
   always_comb begin
      qbit   = (rem >= {2'b00, d});
      diff_s = rem - {2'b00, d};
      if (qbit) begin
         rem_next = {diff_s[11:0], 1'b0};
      end else begin
         rem_next = {rem[11:0], 1'b0};
      end
   end

endmodule

// File: rtl/hp_divider.sv
// Sequential binary16 divider: restoring radix-2 mantissa division, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module hp_divider
   import hp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] hp_inA,
   input  logic [15:0] hp_inB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] hp_quot,
   output logic [1:0]  Exceptions
);

   hp_state_e   state_r, state_s;
   logic [3:0]  cnt_r;
   logic [12:0] rem_r;
   logic [12:0] q_r;
   logic [10:0] d_r;
   logic [4:0]  ea_r, eb_r;
   logic        sign_r;
   logic [15:0] quot_r;
   logic [1:0]  exc_r;
   logic        out_valid_r;
   logic        in_ready_r;

   logic        accept_s, xfer_s, sign_in_s;
   logic        a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
   logic        special_s;
   logic [15:0] spec_quot_s;
   logic [1:0]  spec_exc_s;
   logic        step_qbit_s;
   logic [12:0] step_rem_s;
   logic [9:0]  mant_s, mant_rnd_s;
   logic        guard_s;
   logic signed [6:0] e_base_s, e_diff_s, e_rnd_s;
   logic [15:0] norm_quot_s;
   logic [1:0]  norm_exc_s;

   assign accept_s  = in_valid & in_ready_r;
   assign xfer_s    = out_valid_r & out_ready;
   assign sign_in_s = hp_inA[15] ^ hp_inB[15];

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign hp_quot    = quot_r;
   assign Exceptions = exc_r;

   hp_mant_div_step u_step (
      .rem      (rem_r),
      .d        (d_r),
      .qbit     (step_qbit_s),
      .rem_next (step_rem_s)
   );

   // Classify the incoming operands and resolve results that need no division.
   always_comb begin
      a_zero_s    = is_zero(hp_inA);
      a_inf_s     = is_inf(hp_inA);
      a_nan_s     = is_nan(hp_inA);
      b_zero_s    = is_zero(hp_inB);
      b_inf_s     = is_inf(hp_inB);
      b_nan_s     = is_nan(hp_inB);
      special_s   = 1'b0;
      spec_quot_s = 16'h0000;
      spec_exc_s  = EXC_ZERO;
      if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
         special_s   = 1'b1;
         spec_quot_s = QNAN_VAL;
         spec_exc_s  = EXC_NAN;
      end else if (b_zero_s || a_inf_s) begin
         special_s   = 1'b1;
         spec_quot_s = {sign_in_s, 5'h1F, 10'h000};
         spec_exc_s  = sign_exc(sign_in_s);
      end else if (a_zero_s || b_inf_s) begin
         special_s   = 1'b1;
         spec_quot_s = {sign_in_s, 15'h0000};
         spec_exc_s  = EXC_ZERO;
      end else begin
         special_s   = 1'b0;
      end
   end

   // Normalise the quotient, round half-up on the guard bit and range-check the exponent.
   always_comb begin
      if (q_r[12]) begin
         mant_s   = q_r[11:2];
         guard_s  = q_r[1];
         e_base_s = EBIAS;
      end else begin
         mant_s   = q_r[10:1];
         guard_s  = q_r[0];
         e_base_s = EBIAS - 7'sd1;
      end
      e_diff_s = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + e_base_s;
      if (guard_s && (mant_s == 10'h3FF)) begin
         mant_rnd_s = 10'h000;
         e_rnd_s    = e_diff_s + 7'sd1;
      end else if (guard_s) begin
         mant_rnd_s = mant_s + 10'd1;
         e_rnd_s    = e_diff_s;
      end else begin
         mant_rnd_s = mant_s;
         e_rnd_s    = e_diff_s;
      end
      if (e_rnd_s >= 7'sd31) begin
         norm_quot_s = {sign_r, 5'h1F, 10'h000};
         norm_exc_s  = sign_exc(sign_r);
      end else if (e_rnd_s <= 7'sd0) begin
         norm_quot_s = {sign_r, 15'h0000};
         norm_exc_s  = EXC_ZERO;
      end else begin
         norm_quot_s = {sign_r, e_rnd_s[4:0], mant_rnd_s};
         norm_exc_s  = sign_exc(sign_r);
      end
   end

   // Next-state logic for the IDLE -> DIV -> NORM -> DONE sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && special_s) begin
               state_s = DONE;
            end else if (accept_s) begin
               state_s = DIV;
            end else begin
               state_s = IDLE;
            end
         end
         DIV: begin
            if (cnt_r == 4'(QBITS - 1)) begin
               state_s = NORM;
            end else begin
               state_s = DIV;
            end
         end
         NORM: state_s = DONE;
         DONE: begin
            if (xfer_s) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         rem_r       <= 13'd0;
         q_r         <= 13'd0;
         d_r         <= 11'd0;
         ea_r        <= 5'd0;
         eb_r        <= 5'd0;
         sign_r      <= 1'b0;
         quot_r      <= 16'h0000;
         exc_r       <= EXC_ZERO;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r    <= state_s;
         in_ready_r <= (state_s == IDLE);
         // Result is presented from the second DONE cycle and held until transferred.
         out_valid_r <= (state_r == DONE) && !xfer_s;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  rem_r  <= {2'b01, hp_inA[9:0]};
                  d_r    <= {1'b1, hp_inB[9:0]};
                  ea_r   <= hp_inA[14:10];
                  eb_r   <= hp_inB[14:10];
                  sign_r <= sign_in_s;
                  q_r    <= 13'd0;
                  cnt_r  <= 4'd0;
                  if (special_s) begin
                     quot_r <= spec_quot_s;
                     exc_r  <= spec_exc_s;
                  end
               end
            end
            DIV: begin
               rem_r <= step_rem_s;
               q_r   <= {q_r[11:0], step_qbit_s};
               cnt_r <= cnt_r + 4'd1;
            end
            NORM: begin
               quot_r <= norm_quot_s;
               exc_r  <= norm_exc_s;
               cnt_r  <= 4'd0;
            end
            DONE: begin
               cnt_r <= 4'd0;
            end
            default: begin
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hp_divider.sv
// Scoreboard bench for hp_divider: expected quotient, exception code and latency are queued
// when operands are sent and compared when the result is handed over.
module tb_hp_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] hp_inA;
   logic [15:0] hp_inB;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] hp_quot;
   logic [1:0]  Exceptions;

   typedef struct packed {
      logic [15:0] quot;
      logic [1:0]  exc;
      int          lat;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] quot;
      logic [1:0]  exc;
      int          lat;
   } vec_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   time  accept_t;

   hp_divider dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .hp_inA     (hp_inA),
      .hp_inB     (hp_inB),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .hp_quot    (hp_quot),
      .Exceptions (Exceptions)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic send_op(input vec_t v, input bit push);
      exp_t ent;
      int   n = 0;
      if (push) begin
         ent.quot = v.quot;
         ent.exc  = v.exc;
         ent.lat  = v.lat;
         sb_q.push_back(ent);
      end
      hp_inA   = v.a;
      hp_inB   = v.b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk);
      accept_t = $time;
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(output bit seen, output logic [15:0] q, output logic [1:0] e,
                              output int lat);
      seen = 1'b0;
      q    = 16'h0000;
      e    = 2'b00;
      lat  = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            q    = hp_quot;
            e    = Exceptions;
            lat  = int'(($time - 5 - accept_t) / 10);
         end
      end
      if (seen) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   task automatic run_table(input string tag, input vec_t vecs[]);
      bit          seen;
      logic [15:0] q;
      logic [1:0]  e;
      int          lat;
      exp_t        ent;
      foreach (vecs[i]) begin
         send_op(vecs[i], 1'b1);
         wait_result(seen, q, e, lat);
         ent = sb_q.pop_front();
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL %s[%0d] timeout: out_valid never rose, required %04h", tag, i, ent.quot);
         end
         checks++;
         if (q !== ent.quot || e !== ent.exc) begin
            errors++;
            $display("FAIL %s[%0d] %04h/%04h: got %04h exc %b, required %04h exc %b",
                     tag, i, vecs[i].a, vecs[i].b, q, e, ent.quot, ent.exc);
         end
         checks++;
         if (lat !== ent.lat) begin
            errors++;
            $display("FAIL %s[%0d] latency: got %0d, required %0d", tag, i, lat, ent.lat);
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      hp_inA    = 16'h0000;
      hp_inB    = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || hp_quot !== 16'h0000 || Exceptions !== 2'b00) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b in_ready=%b quot=%04h exc=%b, required 0 1 0000 00",
                  out_valid, in_ready, hp_quot, Exceptions);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_normal();
      vec_t vecs[] = new[6];
      vecs[0] = '{16'h4600, 16'h4000, 16'h4200, 2'b01, 15};
      vecs[1] = '{16'h3C00, 16'h4200, 16'h3555, 2'b01, 15};
      vecs[2] = '{16'hC600, 16'h4000, 16'hC200, 2'b10, 15};
      vecs[3] = '{16'h4000, 16'h4400, 16'h3800, 2'b01, 15};
      vecs[4] = '{16'h3D00, 16'h3E00, 16'h3AAB, 2'b01, 15};
      vecs[5] = '{16'h4000, 16'h4200, 16'h3955, 2'b01, 15};
      run_table("normal", vecs);
   endtask

   task automatic test_range();
      vec_t vecs[] = new[4];
      vecs[0] = '{16'h7BFF, 16'h3800, 16'h7C00, 2'b01, 15};
      vecs[1] = '{16'hFBFF, 16'h3800, 16'hFC00, 2'b10, 15};
      vecs[2] = '{16'h0400, 16'h7BFF, 16'h0000, 2'b00, 15};
      vecs[3] = '{16'h8400, 16'h7BFF, 16'h8000, 2'b00, 15};
      run_table("range", vecs);
   endtask

   task automatic test_special();
      vec_t vecs[] = new[10];
      vecs[0] = '{16'h3C00, 16'h0000, 16'h7C00, 2'b01, 1};
      vecs[1] = '{16'h0000, 16'h0000, 16'hFFFF, 2'b11, 1};
      vecs[2] = '{16'h7E00, 16'h4000, 16'hFFFF, 2'b11, 1};
      vecs[3] = '{16'h7C00, 16'h7C00, 16'hFFFF, 2'b11, 1};
      vecs[4] = '{16'h7C00, 16'hC000, 16'hFC00, 2'b10, 1};
      vecs[5] = '{16'hC000, 16'h7C00, 16'h8000, 2'b00, 1};
      vecs[6] = '{16'h0000, 16'h4000, 16'h0000, 2'b00, 1};
      vecs[7] = '{16'h0001, 16'h4000, 16'h0000, 2'b00, 1};
      vecs[8] = '{16'hBC00, 16'h0000, 16'hFC00, 2'b10, 1};
      vecs[9] = '{16'h4000, 16'h0001, 16'h7C00, 2'b01, 1};
      run_table("special", vecs);
   endtask

   task automatic test_backpressure();
      vec_t        v;
      bit          seen;
      logic [15:0] q;
      logic [1:0]  e;
      int          lat;
      int          n = 0;
      exp_t        ent;
      v = '{16'h4600, 16'h4000, 16'h4200, 2'b01, 15};
      send_op(v, 1'b1);
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_valid_timeout: out_valid=%b required 1", out_valid);
      end
      hp_inA   = 16'h3C00;
      hp_inB   = 16'h0000;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (hp_quot !== 16'h4200 || Exceptions !== 2'b01 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: quot=%04h exc=%b out_valid=%b in_ready=%b, required 4200 01 1 0",
                     i, hp_quot, Exceptions, out_valid, in_ready);
         end
      end
      in_valid = 1'b0;
      wait_result(seen, q, e, lat);
      ent = sb_q.pop_front();
      checks++;
      if (!seen || q !== ent.quot || e !== ent.exc) begin
         errors++;
         $display("FAIL bp_result: seen=%b got %04h exc %b, required %04h exc %b",
                  seen, q, e, ent.quot, ent.exc);
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL bp_ignored: out_valid rose after backpressure, required no queued op");
      end
   endtask

   task automatic test_reset_mid_div();
      vec_t v;
      bit   seen = 1'b0;
      v = '{16'h4600, 16'h4000, 16'h4200, 2'b01, 15};
      send_op(v, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_abort: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      repeat (20) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_discard: aborted result appeared, required none");
      end
      begin
         vec_t vecs[] = new[1];
         vecs[0] = v;
         run_table("post_reset", vecs);
      end
   endtask

   task automatic test_back_to_back();
      vec_t        vecs[3];
      bit          seen;
      logic [15:0] q;
      logic [1:0]  e;
      int          lat;
      exp_t        ent;
      time         prev_t;
      vecs[0] = '{16'hC600, 16'hC000, 16'h4200, 2'b01, 15};
      vecs[1] = '{16'h3C00, 16'h0000, 16'h7C00, 2'b01, 1};
      vecs[2] = '{16'h3C00, 16'hC200, 16'hB555, 2'b10, 15};
      for (int i = 0; i < 3; i++) begin
         prev_t = accept_t;
         send_op(vecs[i], 1'b1);
         if (i > 0) begin
            checks++;
            if (accept_t - prev_t !== time'((vecs[i-1].lat + 2) * 10)) begin
               errors++;
               $display("FAIL b2b_gap[%0d]: accept %0t after previous, required %0d",
                        i, accept_t - prev_t, (vecs[i-1].lat + 2) * 10);
            end
         end
         wait_result(seen, q, e, lat);
         ent = sb_q.pop_front();
         checks++;
         if (!seen || q !== ent.quot || e !== ent.exc || lat !== ent.lat) begin
            errors++;
            $display("FAIL b2b[%0d]: seen=%b got %04h exc %b lat %0d, required %04h exc %b lat %0d",
                     i, seen, q, e, lat, ent.quot, ent.exc, ent.lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_range();
      test_special();
      test_backpressure();
      test_reset_mid_div();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
